// File: rtl/forwarding_control_unit.sv
// ============================================================================
// forwarding_control_unit: destination-tag pipeline and operand bypass selects
// Revision: 1.0
// ============================================================================
`default_nettype none

module forwarding_control_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic [ADDR_W-1:0] RW_dm,
  output logic              we_dm,
  output logic [CNT_W-1:0]  fwd_count
);

  localparam logic [1:0] SEL_BANK = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_DM   = 2'b10;
  localparam logic [1:0] SEL_WB   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0] ex_addr_q,  ex_addr_d;
  logic              dm_valid_q, dm_valid_d;
  logic [ADDR_W-1:0] dm_addr_q,  dm_addr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [1:0]        sel_a_q,    sel_a_d;
  logic [1:0]        sel_b_q,    sel_b_d;
  logic [CNT_W-1:0]  fwd_count_q, fwd_count_d;

  // Youngest producer wins; register 0 is an ordinary forwardable address.
  function automatic logic [1:0] pick_source(
    input logic [ADDR_W-1:0] src,
    input logic              ex_v,
    input logic [ADDR_W-1:0] ex_a,
    input logic              dm_v,
    input logic [ADDR_W-1:0] dm_a,
    input logic              wb_v,
    input logic [ADDR_W-1:0] wb_a
  );
    logic [1:0] sel;
    sel = SEL_BANK;
    if (ex_v && (ex_a == src)) begin
      sel = SEL_EX;
    end else if (dm_v && (dm_a == src)) begin
      sel = SEL_DM;
    end else if (wb_v && (wb_a == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_addr_d   = ex_addr_q;
    dm_valid_d  = dm_valid_q;
    dm_addr_d   = dm_addr_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    fwd_count_d = fwd_count_q;

    if (!hold) begin
      ex_valid_d = issue & wr_en & ~flush;
      ex_addr_d  = RW;
      dm_valid_d = ex_valid_q;
      dm_addr_d  = ex_addr_q;
      wb_valid_d = dm_valid_q;
      wb_addr_d  = dm_addr_q;

      // Selects are resolved against pre-edge tags so they line up with the
      // registered bank read data on the next cycle.
      if (issue && !flush) begin
        sel_a_d = pick_source(RA, ex_valid_q, ex_addr_q, dm_valid_q, dm_addr_q,
                              wb_valid_q, wb_addr_q);
        sel_b_d = pick_source(RB, ex_valid_q, ex_addr_q, dm_valid_q, dm_addr_q,
                              wb_valid_q, wb_addr_q);
      end else begin
        sel_a_d = SEL_BANK;
        sel_b_d = SEL_BANK;
      end

      if (((sel_a_d != SEL_BANK) || (sel_b_d != SEL_BANK)) &&
          (fwd_count_q != CNT_MAX)) begin
        fwd_count_d = fwd_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_addr_q   <= '0;
      dm_valid_q  <= 1'b0;
      dm_addr_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      sel_a_q     <= SEL_BANK;
      sel_b_q     <= SEL_BANK;
      fwd_count_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_addr_q   <= ex_addr_d;
      dm_valid_q  <= dm_valid_d;
      dm_addr_q   <= dm_addr_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      fwd_count_q <= fwd_count_d;
    end
  end

  assign mux_sel_A = sel_a_q;
  assign mux_sel_B = sel_b_q;
  assign RW_dm     = dm_addr_q;
  assign we_dm     = dm_valid_q;
  assign fwd_count = fwd_count_q;

endmodule

`default_nettype wire

// File: tb/tb_forwarding_control_unit.sv
// ============================================================================
// tb_forwarding_control_unit: directed vectors for the forwarding control unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_forwarding_control_unit;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              issue;
  logic              wr_en;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] rw;
  logic              hold;
  logic              flush;
  logic [1:0]        mux_sel_a;
  logic [1:0]        mux_sel_b;
  logic [ADDR_W-1:0] rw_dm;
  logic              we_dm;
  logic [CNT_W-1:0]  fwd_count;

  int checks;
  int errors;

  forwarding_control_unit #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue),
    .wr_en    (wr_en),
    .RA       (ra),
    .RB       (rb),
    .RW       (rw),
    .hold     (hold),
    .flush    (flush),
    .mux_sel_A(mux_sel_a),
    .mux_sel_B(mux_sel_b),
    .RW_dm    (rw_dm),
    .we_dm    (we_dm),
    .fwd_count(fwd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one decode-cycle of inputs, clock it, then sample just after the edge.
  task automatic step(input logic i_issue, input logic i_wr, input logic [ADDR_W-1:0] i_ra,
                      input logic [ADDR_W-1:0] i_rb, input logic [ADDR_W-1:0] i_rw,
                      input logic i_flush, input logic i_hold);
    issue = i_issue;
    wr_en = i_wr;
    ra    = i_ra;
    rb    = i_rb;
    rw    = i_rw;
    flush = i_flush;
    hold  = i_hold;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel_a"}, {30'd0, mux_sel_a}, 32'd0);
    check({tag, "_sel_b"}, {30'd0, mux_sel_b}, 32'd0);
    check({tag, "_rw_dm"}, {27'd0, rw_dm}, 32'd0);
    check({tag, "_we_dm"}, {31'd0, we_dm}, 32'd0);
    check({tag, "_count"}, {28'd0, fwd_count}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    issue  = 1'b0;
    wr_en  = 1'b0;
    ra     = '0;
    rb     = '0;
    rw     = '0;
    hold   = 1'b0;
    flush  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Back-to-back dependency: EX forward
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    check("first_issue_sel_a", {30'd0, mux_sel_a}, 32'd0);
    check("first_issue_sel_b", {30'd0, mux_sel_b}, 32'd0);
    step(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    check("b2b_sel_a", {30'd0, mux_sel_a}, 32'd1);
    check("b2b_sel_b", {30'd0, mux_sel_b}, 32'd0);
    check("b2b_count", {28'd0, fwd_count}, 32'd1);
    check("b2b_we_dm", {31'd0, we_dm}, 32'd1);
    check("b2b_rw_dm", {27'd0, rw_dm}, 32'd5);
    drain();

    // One bubble: DM forward on B
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    check("bub1_sel_b", {30'd0, mux_sel_b}, 32'd2);
    check("bub1_sel_a", {30'd0, mux_sel_a}, 32'd0);
    drain();

    // Two bubbles: WB forward on B
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    check("bub2_sel_b", {30'd0, mux_sel_b}, 32'd3);
    check("bub2_count", {28'd0, fwd_count}, 32'd3);
    drain();

    // Three bubbles: producer retired, read from bank
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    check("bub3_sel_b", {30'd0, mux_sel_b}, 32'd0);
    check("bub3_count", {28'd0, fwd_count}, 32'd3);
    drain();

    // Two producers of r3: youngest (EX) wins
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    check("prio_sel_a", {30'd0, mux_sel_a}, 32'd1);
    check("prio_sel_b", {30'd0, mux_sel_b}, 32'd1);
    check("prio_count", {28'd0, fwd_count}, 32'd4);
    drain();

    // A and B resolved against different stages
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd10, 5'd11, 5'd0, 1'b0, 1'b0);
    check("indep_sel_a", {30'd0, mux_sel_a}, 32'd2);
    check("indep_sel_b", {30'd0, mux_sel_b}, 32'd1);
    drain();

    // Register 0 forwards like any other
    step(1'b1, 1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0);
    check("r0_sel_a", {30'd0, mux_sel_a}, 32'd1);
    check("r0_sel_b", {30'd0, mux_sel_b}, 32'd0);
    check("r0_count", {28'd0, fwd_count}, 32'd6);
    drain();

    // No issue: selects zero despite a match
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    check("noissue_sel_a", {30'd0, mux_sel_a}, 32'd0);
    check("noissue_sel_b", {30'd0, mux_sel_b}, 32'd0);
    check("noissue_count", {28'd0, fwd_count}, 32'd6);
    drain();

    // Flush: kills incoming EX tag and selects; older tags still shift
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0);
    check("flush_sel_a", {30'd0, mux_sel_a}, 32'd0);
    check("flush_sel_b", {30'd0, mux_sel_b}, 32'd0);
    check("flush_we_dm", {31'd0, we_dm}, 32'd1);
    check("flush_rw_dm", {27'd0, rw_dm}, 32'd8);
    step(1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    check("flushed_sel_a", {30'd0, mux_sel_a}, 32'd0);
    check("flushed_we_dm", {31'd0, we_dm}, 32'd0);
    check("flush_count", {28'd0, fwd_count}, 32'd6);
    drain();

    // Hold freezes tags, selects and count; flush ignored while held
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0);
    check("prehold_sel_a", {30'd0, mux_sel_a}, 32'd1);
    check("prehold_count", {28'd0, fwd_count}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      check("hold_sel_a", {30'd0, mux_sel_a}, 32'd1);
      check("hold_count", {28'd0, fwd_count}, 32'd7);
      check("hold_we_dm", {31'd0, we_dm}, 32'd1);
    end
    step(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    check("posthold_sel_a", {30'd0, mux_sel_a}, 32'd1);
    check("posthold_count", {28'd0, fwd_count}, 32'd8);
    drain();

    // Saturation of the 4-bit counter
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
    check("sat_count", {28'd0, fwd_count}, 32'd15);
    check("sat_sel_a", {30'd0, mux_sel_a}, 32'd1);

    // Asynchronous reset mid-stall clears everything without a clock edge
    step(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
    check("post_rst_sel_a", {30'd0, mux_sel_a}, 32'd0);
    check("post_rst_sel_b", {30'd0, mux_sel_b}, 32'd0);
    check("post_rst_count", {28'd0, fwd_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/forwarding_control_unit.md
FORWARDING_CONTROL_UNIT -- requirements
Module: forwarding_control_unit

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 5, which is the register-address width (32 registers).
REQ-002 The block SHALL have the parameter CNT_W, default 16, which is the width of the forwarding-hit counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port issue, input, 1 bit: an instruction is in decode this cycle.
REQ-006 The block SHALL have port wr_en, input, 1 bit: the issuing instruction writes a register.
REQ-007 The block SHALL have ports RA and RB, input, ADDR_W each: source register addresses of the issuing instruction.
REQ-008 The block SHALL have port RW, input, ADDR_W: destination address of the issuing instruction.
REQ-009 The block SHALL have port hold, input, 1 bit: pipeline stall; all state frozen.
REQ-010 The block SHALL have port flush, input, 1 bit: kill the youngest in-flight instruction (EX tag).
REQ-011 The block SHALL have ports mux_sel_A and mux_sel_B, output, 2 bits each: operand source selects: 00 register bank, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-012 The block SHALL have port RW_dm, output, ADDR_W: register-bank write address (DM-stage tag).
REQ-013 The block SHALL have port we_dm, output, 1 bit: the DM-stage tag is valid and writes.
REQ-014 The block SHALL have port fwd_count, output, CNT_W: saturating count of cycles with any non-zero select.

Function
REQ-015 The block SHALL hold three tag stages {valid, addr}: EX, DM, WB.
REQ-016 On each edge with hold=0, the tag stages SHALL shift as EX <= {issue&wr_en&~flush, RW}, DM <= EX, WB <= DM.
REQ-017 On each edge with hold=0, selects SHALL be computed from the pre-edge tags and registered, aligning them with the bank's registered AR/BR.
REQ-018 mux_sel_A SHALL be 01 if EX.valid and EX.addr==RA; else 10 if DM.valid and DM.addr==RA; else 11 if WB.valid and WB.addr==RA; else 00.
REQ-019 Forwarding priority SHALL be youngest first: EX over DM over WB.
REQ-020 mux_sel_B SHALL use the same rule as mux_sel_A, against RB.
REQ-021 Register 0 SHALL receive no special case; every address SHALL be forwardable.
REQ-022 When issue=0, the registered selects SHALL be 00 regardless of RA/RB.
REQ-023 When flush=1 with hold=0, the incoming EX tag SHALL be invalid and the selects SHALL be 00; DM and WB SHALL shift normally.
REQ-024 When hold=1, all tags, selects and fwd_count SHALL keep their values; flush SHALL be ignored.
REQ-025 RW_dm and we_dm SHALL be driven combinationally from the DM tag, with no added latency.
REQ-026 fwd_count SHALL increment by 1 on each hold=0 edge where either newly registered select is non-zero.
REQ-027 fwd_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 A same-edge match of RA and RB against different stages SHALL be resolved independently for each operand.

Reset
REQ-029 On rst_n low (asynchronous, at any time, including mid-stall), all tag valids SHALL go to 0, tag addrs to 0, mux_sel_A/B to 00, fwd_count to 0, RW_dm to 0 and we_dm to 0.
REQ-030 After rst_n rises, the first issued instruction SHALL see only 00 selects.

Verification
REQ-031 Back-to-back issue of I1 (RW=5, wr_en=1) then I2 (RA=5) SHALL give mux_sel_A=01 after I2's edge.
REQ-032 Issue of RW=7, then a bubble, then RB=7 SHALL give mux_sel_B=10; with two bubbles it SHALL give 11, and with three bubbles 00.
REQ-033 Issue of RW=3, then RW=3, then RA=3, RB=3 SHALL give mux_sel_A=01 and mux_sel_B=01, confirming youngest-first priority.
REQ-034 Issue of RW=9 with flush=1, then RA=9, SHALL give mux_sel_A=00, and we_dm SHALL be 0 two edges later.
REQ-035 Issue of RW=4, then hold=1 for 3 cycles, then RA=4 with hold=0 SHALL give mux_sel_A=01, and fwd_count SHALL be unchanged during hold.
REQ-036 Forcing fwd_count near its maximum (CNT_W=4, 20 forwarding cycles) SHALL give fwd_count=15, and rst_n pulsed low mid-sequence SHALL zero all outputs immediately.
